// File: rtl/bp_gshare_ctrl_if.sv
// bp_gshare_ctrl_if: fetch, PHT and resolve signals between a core and the gshare controller.
interface bp_gshare_ctrl_if #(parameter int INDEX_WIDTH = 8);
  logic                   fetch_valid_i;
  logic [31:0]            fetch_pc_i;
  logic                   fetch_ready_o;
  logic                   pred_taken_o;
  logic [INDEX_WIDTH-1:0] pht_rd_index_o;
  logic                   pht_prediction_i;
  logic                   resolve_valid_i;
  logic                   resolve_taken_i;
  logic                   pht_update_en_o;
  logic [INDEX_WIDTH-1:0] pht_update_index_o;
  logic                   pht_br_taken_o;
  logic                   mispredict_o;
  logic                   resolve_err_o;
  logic [INDEX_WIDTH-1:0] ghr_o;
  modport slave (
    input  fetch_valid_i, fetch_pc_i, pht_prediction_i, resolve_valid_i, resolve_taken_i,
    output fetch_ready_o, pred_taken_o, pht_rd_index_o, pht_update_en_o, pht_update_index_o,
           pht_br_taken_o, mispredict_o, resolve_err_o, ghr_o
  );
  modport master (
    output fetch_valid_i, fetch_pc_i, pht_prediction_i, resolve_valid_i, resolve_taken_i,
    input  fetch_ready_o, pred_taken_o, pht_rd_index_o, pht_update_en_o, pht_update_index_o,
           pht_br_taken_o, mispredict_o, resolve_err_o, ghr_o
  );
endinterface

// File: rtl/bp_gshare_ctrl.sv
// bp_gshare_ctrl: gshare prediction control with speculative GHR and an in-order FIFO of unresolved branches.
module bp_gshare_ctrl #(
  parameter int INDEX_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  bp_gshare_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  logic [INDEX_WIDTH-1:0] ghr;
  logic [INDEX_WIDTH-1:0] idx_q  [DEPTH];
  logic [INDEX_WIDTH-2:0] hist_q [DEPTH];
  logic [DEPTH-1:0]       pred_q;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW:0]            count;
  logic                   push, pop, mis, err;
  always_comb begin
    bus.pht_rd_index_o = bus.fetch_pc_i[INDEX_WIDTH+1:2] ^ ghr;
    bus.pred_taken_o   = bus.pht_prediction_i;
    bus.fetch_ready_o  = !count[PW];
    bus.ghr_o          = ghr;
    pop  = bus.resolve_valid_i && count != '0;
    err  = bus.resolve_valid_i && count == '0;
    mis  = pop && (bus.resolve_taken_i != pred_q[rd_ptr]);
    push = bus.fetch_valid_i && !count[PW] && !mis;
  end
  // Only the low bits of the pre-shift GHR are kept; recovery shifts the top bit out anyway.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_q[wr_ptr]  <= bus.pht_rd_index_o;
      hist_q[wr_ptr] <= ghr[INDEX_WIDTH-2:0];
      pred_q[wr_ptr] <= bus.pht_prediction_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr                    <= '0;
      count                  <= '0;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      bus.pht_update_en_o    <= 1'b0;
      bus.pht_update_index_o <= '0;
      bus.pht_br_taken_o     <= 1'b0;
      bus.mispredict_o       <= 1'b0;
      bus.resolve_err_o      <= 1'b0;
    end else begin
      bus.pht_update_en_o    <= pop;
      bus.pht_update_index_o <= pop ? idx_q[rd_ptr] : bus.pht_update_index_o;
      bus.pht_br_taken_o     <= pop ? bus.resolve_taken_i : bus.pht_br_taken_o;
      bus.mispredict_o       <= mis;
      bus.resolve_err_o      <= err;
      ghr    <= mis ? {hist_q[rd_ptr], bus.resolve_taken_i} : push ? {ghr[INDEX_WIDTH-2:0], bus.pht_prediction_i} : ghr;
      count  <= mis ? '0 : count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      rd_ptr <= mis ? '0 : pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr <= mis ? '0 : push ? wr_ptr + PW'(1) : wr_ptr;
    end
  end
endmodule

// File: tb/tb_bp_gshare_ctrl.sv
// tb_bp_gshare_ctrl: directed and randomized checks of bp_gshare_ctrl against a queue-based model.
module tb_bp_gshare_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int errors = 0;
  bp_gshare_ctrl_if #(.INDEX_WIDTH(4)) bus();
  bp_gshare_ctrl #(.INDEX_WIDTH(4), .DEPTH(2)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] idx;
    logic       pred;
    logic [3:0] ghr;
  } ent_t;
  ent_t q[$];
  logic [3:0] m_ghr;
  logic       e_upd, e_tk, e_mis, e_err;
  logic [3:0] e_idx;
  logic [3:0] e_rdidx;

  task automatic model_reset();
    q.delete();
    m_ghr = 4'd0;
    e_upd = 0; e_tk = 0; e_mis = 0; e_err = 0; e_idx = 4'd0;
  endtask

  task automatic set_inputs(input logic fv, input logic [31:0] pc, input logic pp, input logic rv, input logic rt);
    bus.fetch_valid_i    = fv;
    bus.fetch_pc_i       = pc;
    bus.pht_prediction_i = pp;
    bus.resolve_valid_i  = rv;
    bus.resolve_taken_i  = rt;
    e_rdidx = pc[5:2] ^ m_ghr;
    #1;
  endtask

  task automatic tick();
    int   n;
    logic accept;
    ent_t e;
    @(posedge clk_i);
    n = q.size();
    accept = bus.fetch_valid_i && n < 2;
    e_upd = 0; e_mis = 0;
    e_err = bus.resolve_valid_i && n == 0;
    if (bus.resolve_valid_i && n > 0) begin
      e = q.pop_front();
      e_upd = 1;
      e_idx = e.idx;
      e_tk  = bus.resolve_taken_i;
      if (bus.resolve_taken_i != e.pred) begin
        e_mis = 1;
        q.delete();
        m_ghr = {e.ghr[2:0], bus.resolve_taken_i};
        accept = 0;
      end
    end
    if (accept) begin
      q.push_back('{idx: e_rdidx, pred: bus.pht_prediction_i, ghr: m_ghr});
      m_ghr = {m_ghr[2:0], bus.pht_prediction_i};
    end
    #1;
  endtask

  task automatic do_reset();
    set_inputs(0, 32'd0, 0, 0, 0);
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    set_inputs(0, 32'd0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    checks++; if (bus.ghr_o !== 4'd0) begin errors++; $display("FAIL reset_ghr got %h exp 0", bus.ghr_o); end
    checks++; if (bus.pht_update_en_o !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", bus.pht_update_en_o); end
    checks++; if (bus.pht_update_index_o !== 4'd0) begin errors++; $display("FAIL reset_uidx got %h exp 0", bus.pht_update_index_o); end
    checks++; if (bus.pht_br_taken_o !== 1'b0) begin errors++; $display("FAIL reset_tk got %b exp 0", bus.pht_br_taken_o); end
    checks++; if (bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", bus.mispredict_o); end
    checks++; if (bus.resolve_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.resolve_err_o); end
    do_reset();
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.fetch_ready_o); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_inputs(1, 32'h10, 0, 0, 0);
    checks++; if (bus.pht_rd_index_o !== 4'd4) begin errors++; $display("FAIL mp_rdidx got %h exp 4", bus.pht_rd_index_o); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL mp_pred got %b exp 0", bus.pred_taken_o); end
    tick();
    checks++; if (bus.ghr_o !== 4'd0) begin errors++; $display("FAIL mp_ghr0 got %h exp 0", bus.ghr_o); end
    set_inputs(0, 32'd0, 0, 1, 1);
    tick();
    checks++; if (bus.pht_update_en_o !== 1'b1) begin errors++; $display("FAIL mp_upd got %b exp 1", bus.pht_update_en_o); end
    checks++; if (bus.pht_update_index_o !== 4'd4) begin errors++; $display("FAIL mp_uidx got %h exp 4", bus.pht_update_index_o); end
    checks++; if (bus.pht_br_taken_o !== 1'b1) begin errors++; $display("FAIL mp_tk got %b exp 1", bus.pht_br_taken_o); end
    checks++; if (bus.mispredict_o !== 1'b1) begin errors++; $display("FAIL mp_mis got %b exp 1", bus.mispredict_o); end
    checks++; if (bus.ghr_o !== 4'b0001) begin errors++; $display("FAIL mp_ghr got %h exp 1", bus.ghr_o); end
    set_inputs(0, 32'd0, 0, 0, 0);
    tick();
    checks++; if (bus.mispredict_o !== 1'b0 || bus.pht_update_en_o !== 1'b0) begin errors++; $display("FAIL mp_pulse mis=%b upd=%b exp 0 0", bus.mispredict_o, bus.pht_update_en_o); end
  endtask

  task automatic test_full();
    do_reset();
    set_inputs(1, 32'h40, 1, 0, 0); tick();
    set_inputs(1, 32'h84, 1, 0, 0); tick();
    checks++; if (bus.ghr_o !== 4'b0011) begin errors++; $display("FAIL full_ghr got %h exp 3", bus.ghr_o); end
    checks++; if (bus.fetch_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.fetch_ready_o); end
    set_inputs(1, 32'hC8, 1, 0, 0); tick();
    checks++; if (bus.ghr_o !== 4'b0011) begin errors++; $display("FAIL full_ignored ghr got %h exp 3", bus.ghr_o); end
    set_inputs(0, 32'd0, 0, 1, 1);
    checks++; if (bus.fetch_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_indep got %b exp 0", bus.fetch_ready_o); end
    tick();
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL full_freed got %b exp 1", bus.fetch_ready_o); end
    checks++; if (bus.pht_update_index_o !== 4'd0 || bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL full_resolve uidx=%h mis=%b exp 0 0", bus.pht_update_index_o, bus.mispredict_o); end
  endtask

  task automatic test_resolve_err();
    do_reset();
    set_inputs(1, 32'h14, 1, 0, 0); tick();
    set_inputs(0, 32'd0, 0, 1, 1); tick();
    set_inputs(0, 32'd0, 0, 1, 0); tick();
    checks++; if (bus.resolve_err_o !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", bus.resolve_err_o); end
    checks++; if (bus.pht_update_en_o !== 1'b0 || bus.mispredict_o !== 1'b0) begin errors++; $display("FAIL err_side upd=%b mis=%b exp 0 0", bus.pht_update_en_o, bus.mispredict_o); end
    checks++; if (bus.ghr_o !== m_ghr) begin errors++; $display("FAIL err_ghr got %h exp %h", bus.ghr_o, m_ghr); end
    set_inputs(0, 32'd0, 0, 0, 0); tick();
    checks++; if (bus.resolve_err_o !== 1'b0) begin errors++; $display("FAIL err_once got %b exp 0", bus.resolve_err_o); end
  endtask

  task automatic test_mis_fetch();
    do_reset();
    set_inputs(1, 32'h20, 0, 0, 0); tick();
    set_inputs(1, 32'h3C, 1, 1, 1); tick();
    checks++; if (bus.mispredict_o !== 1'b1) begin errors++; $display("FAIL mf_mis got %b exp 1", bus.mispredict_o); end
    checks++; if (bus.ghr_o !== 4'b0001 || bus.ghr_o !== m_ghr) begin errors++; $display("FAIL mf_ghr got %h exp %h", bus.ghr_o, m_ghr); end
    set_inputs(0, 32'd0, 0, 1, 0); tick();
    checks++; if (bus.resolve_err_o !== 1'b1 || bus.pht_update_en_o !== 1'b0) begin errors++; $display("FAIL mf_dropped err=%b upd=%b exp 1 0", bus.resolve_err_o, bus.pht_update_en_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_inputs(1, 32'h44, 1, 0, 0); tick();
    set_inputs(1, 32'h48, 0, 1, 1); tick();
    set_inputs(1, 32'h4C, 1, 0, 0); tick();
    set_inputs(0, 32'd0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    checks++; if ({bus.ghr_o, bus.pht_update_en_o, bus.pht_update_index_o, bus.pht_br_taken_o, bus.mispredict_o, bus.resolve_err_o} !== 12'd0) begin errors++; $display("FAIL ar_outputs ghr=%h upd=%b uidx=%h exp all 0", bus.ghr_o, bus.pht_update_en_o, bus.pht_update_index_o); end
    #1 rst_ni = 1'b1;
    tick();
    checks++; if (bus.fetch_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", bus.fetch_ready_o); end
    set_inputs(0, 32'd0, 0, 1, 1); tick();
    checks++; if (bus.pht_update_en_o !== 1'b0 || bus.resolve_err_o !== 1'b1) begin errors++; $display("FAIL ar_no_strobe upd=%b err=%b exp 0 1", bus.pht_update_en_o, bus.resolve_err_o); end
  endtask

  task automatic test_back_to_back();
    int strobes = 0;
    do_reset();
    set_inputs(1, {$urandom} & 32'h3C, 1'($urandom), 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      set_inputs(1, $urandom, 1'($urandom), 1, q[0].pred);
      tick();
      strobes += int'(bus.pht_update_en_o);
      checks++; if (bus.pht_update_en_o !== 1'b1 || bus.pht_update_index_o !== e_idx) begin errors++; $display("FAIL b2b_upd[%0d] upd=%b uidx=%h exp 1 %h", i, bus.pht_update_en_o, bus.pht_update_index_o, e_idx); end
      checks++; if (bus.mispredict_o !== 1'b0 || bus.ghr_o !== m_ghr) begin errors++; $display("FAIL b2b_state[%0d] mis=%b ghr=%h exp 0 %h", i, bus.mispredict_o, bus.ghr_o, m_ghr); end
    end
    checks++; if (strobes != 10) begin errors++; $display("FAIL b2b_strobes got %0d exp 10", strobes); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_inputs(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom));
      checks++; if (bus.pht_rd_index_o !== e_rdidx || bus.pred_taken_o !== bus.pht_prediction_i) begin errors++; $display("FAIL rnd_comb[%0d] rdidx=%h pred=%b exp %h %b", i, bus.pht_rd_index_o, bus.pred_taken_o, e_rdidx, bus.pht_prediction_i); end
      checks++; if (bus.fetch_ready_o !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, bus.fetch_ready_o, q.size() < 2); end
      tick();
      checks++; if (bus.pht_update_en_o !== e_upd || bus.mispredict_o !== e_mis || bus.resolve_err_o !== e_err) begin errors++; $display("FAIL rnd_pulses[%0d] upd/mis/err=%b%b%b exp %b%b%b", i, bus.pht_update_en_o, bus.mispredict_o, bus.resolve_err_o, e_upd, e_mis, e_err); end
      checks++; if (bus.ghr_o !== m_ghr) begin errors++; $display("FAIL rnd_ghr[%0d] got %h exp %h", i, bus.ghr_o, m_ghr); end
      if (e_upd) begin
        checks++; if (bus.pht_update_index_o !== e_idx || bus.pht_br_taken_o !== e_tk) begin errors++; $display("FAIL rnd_update[%0d] uidx=%h tk=%b exp %h %b", i, bus.pht_update_index_o, bus.pht_br_taken_o, e_idx, e_tk); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_full();
    test_resolve_err();
    test_mis_fetch();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
